// File: rtl/alu_seq_if.sv
// Operand/result bundle between the register-file read ports, the sequential ALU and writeback.
// Latency: none. This is wiring only.
// Backpressure: the control unit must hold off start while busy is high. A start seen during busy is dropped.
//
// Signal groups:
//   request : start, a, b, alu_op, shamt            (master -> slave)
//   status  : busy, done                            (slave  -> master)
//   result  : r, zero, overflow, carry              (slave  -> master)
// Modports:
//   master  - control unit / operand source
//   slave   - alu_seq
interface alu_seq_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [3:0]         alu_op;
    logic [SHAMT_W-1:0] shamt;

    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   r;
    logic               zero;
    logic               overflow;
    logic               carry;

    modport master (
        output start, a, b, alu_op, shamt,
        input  busy, done, r, zero, overflow, carry
    );

    modport slave (
        input  start, a, b, alu_op, shamt,
        output busy, done, r, zero, overflow, carry
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with flags, iterative shift-add multiply and restoring divide.
// Latency: single-cycle ops complete 1 clock after acceptance; mul/div (b!=0) complete WIDTH+1 clocks after acceptance.
// Backpressure: busy is high while mul/div iterate. start is sampled only when busy is low, including the done cycle.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset. It aborts any operation in flight and no done pulse follows.
//   bus    - alu_seq_if.slave carrying:
//            start, a, b, alu_op, shamt (inputs)
//            busy, done, r, zero, overflow, carry (outputs)
// Parameters: WIDTH (>= 4), SHAMT_W (= clog2(WIDTH)).
// Build option: define ALU_SHIFT_EN to enable sll (1100) and srl (1101).
//   Without it, both opcodes decode as undefined (r=0) and shamt is ignored.
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);

    localparam int MSB   = WIDTH - 1;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_NOTB = 4'b1001;
    localparam logic [3:0] OP_NAND = 4'b1010;
    localparam logic [3:0] OP_PASS = 4'b1011;
`ifdef ALU_SHIFT_EN
    localparam logic [3:0] OP_SLL  = 4'b1100;
    localparam logic [3:0] OP_SRL  = 4'b1101;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   r_q;
    logic               zero_q;
    logic               ovf_q;
    logic               carry_q;

    // Shared iteration datapath.
    // For mul, acc holds {partial-product high half, remaining multiplier bits}.
    // For div, acc holds {partial remainder, dividend bits that become quotient bits}.
    // opnd holds the multiplicand or the divisor.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [CNT_W-1:0]   cnt;

    // ---------------------------------------------------------------
    // Single-cycle result path, evaluated on the live request inputs.
    // It is only registered on the accepting edge.
    // ---------------------------------------------------------------
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [WIDTH-1:0]   sc_r;
    logic               sc_c;
    logic               sc_v;

    assign add_s = {1'b0, bus.a} + {1'b0, bus.b};
    // Bit WIDTH of the zero-extended difference is set exactly when a < b (unsigned), i.e. the borrow.
    assign sub_s = {1'b0, bus.a} - {1'b0, bus.b};

`ifndef ALU_SHIFT_EN
    // Shift amount has no consumer in this build.
    logic unused_shamt;
    assign unused_shamt = ^bus.shamt;
`endif

    always_comb begin
        sc_r = '0;
        sc_c = 1'b0;
        sc_v = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                sc_r = add_s[MSB:0];
                sc_c = add_s[WIDTH];
                // Signed overflow: operands agree in sign and the result disagrees.
                sc_v = (bus.a[MSB] == bus.b[MSB]) && (add_s[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                sc_r = sub_s[MSB:0];
                sc_c = sub_s[WIDTH];
                // Signed overflow: operands differ in sign and the result takes b's sign.
                sc_v = (bus.a[MSB] != bus.b[MSB]) && (sub_s[MSB] != bus.a[MSB]);
            end
            OP_DIV: begin
                // Only reached as a single-cycle op when b == 0. Saturate and flag it.
                sc_r = '1;
                sc_v = 1'b1;
            end
            OP_AND:  sc_r = bus.a & bus.b;
            OP_OR:   sc_r = bus.a | bus.b;
            OP_NOR:  sc_r = ~(bus.a | bus.b);
            OP_XOR:  sc_r = bus.a ^ bus.b;
            OP_NOTB: sc_r = ~bus.b;
            OP_NAND: sc_r = ~(bus.a & bus.b);
            OP_PASS: sc_r = bus.b;
`ifdef ALU_SHIFT_EN
            OP_SLL:  sc_r = bus.a << bus.shamt;
            OP_SRL:  sc_r = bus.a >> bus.shamt;
`endif
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // One iteration step for each of the multi-cycle ops.
    // ---------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;

    // Shift-add: conditionally add the multiplicand into the high half, then shift the whole accumulator right.
    // The add's carry-out shifts into the top bit.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder, then try a subtract.
    // If it borrows, keep the shifted remainder and record a 0 quotient bit.
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[MSB:0], acc[WIDTH-2:0], 1'b1};

    logic mul_req;
    logic div_req;

    assign mul_req = (bus.alu_op == OP_MUL);
    assign div_req = (bus.alu_op == OP_DIV) && (bus.b != '0);

    // ---------------------------------------------------------------
    // Control FSM and result registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            r_q     <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            acc     <= '0;
            opnd    <= '0;
            cnt     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                // DONE behaves like IDLE for acceptance. busy is already low, so a back-to-back start is taken.
                IDLE, DONE: begin
                    state <= IDLE;
                    if (bus.start) begin
                        if (mul_req || div_req) begin
                            state  <= mul_req ? MUL : DIV;
                            busy_q <= 1'b1;
                            opnd   <= bus.b;
                            acc    <= {{WIDTH{1'b0}}, bus.a};
                            cnt    <= '0;
                        end else begin
                            r_q     <= sc_r;
                            zero_q  <= (sc_r == '0);
                            ovf_q   <= sc_v;
                            carry_q <= sc_c;
                            done_q  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        r_q     <= mul_next[MSB:0];
                        zero_q  <= (mul_next[MSB:0] == '0);
                        ovf_q   <= (mul_next[2*WIDTH-1:WIDTH] != '0);
                        carry_q <= 1'b0;
                    end
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        r_q     <= div_next[MSB:0];
                        zero_q  <= (div_next[MSB:0] == '0);
                        ovf_q   <= 1'b0;
                        carry_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.r        = r_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
    assign bus.carry    = carry_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU.
- Same opcode map, plus registered flags and iterative multi-cycle multiply and divide. These replace the combinational `*` and `/`.
- Uses a start/busy/done handshake so the control unit can stall on long operations.
- Sits between the register-file read ports and the writeback mux.

Parameters:
- WIDTH, 32: operand and result width in bits; must be at least 4.
- SHAMT_W, 5: shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while busy=0
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alu_op  input  4  opcode
- shamt  input  SHAMT_W  shift amount
- busy  output  1  multi-cycle operation in progress
- done  output  1  one-cycle pulse; r and flags are valid from this cycle
- r  output  WIDTH  result, held until the next accepted start
- zero  output  1  r == 0
- overflow  output  1  arithmetic overflow or divide-by-zero
- carry  output  1  add carry-out, or sub borrow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: r=0, zero=1, overflow=0, carry=0, busy=0, done=0, FSM in IDLE.
- Reset mid-operation aborts the operation; no done pulse is produced.
- Acceptance: start=1 with busy=0 at edge N. Operands, opcode and shamt are captured at that edge and ignored afterwards. start while busy=1 is ignored.
- Opcodes:
  - 0001 add: r=a+b; carry=carry-out; overflow=signed overflow.
  - 0010 sub: r=a-b; carry=borrow (a<b unsigned); overflow=signed overflow.
  - 0011 mul: unsigned; r=low WIDTH bits of the product; overflow=1 if high WIDTH bits are nonzero.
  - 0100 div: unsigned quotient; remainder discarded.
  - 0101 and; 0110 or; 0111 nor; 1000 xor; 1001 not b; 1010 nand; 1011 pass b.
  - 1100 sll and 1101 srl: see Optional Feature.
- Flags for logic, pass and shift ops: carry=0, overflow=0.
- Undefined opcodes (0000, 1110, 1111): r=0, zero=1, carry=0, overflow=0. Single-cycle latency.
- FSM states: IDLE, MUL, DIV, DONE.
- Single-cycle ops: result registered at edge N+1 with done=1 for that cycle. busy stays 0 and the FSM stays in IDLE.
- MUL (shift-add, one bit per cycle):
  - IDLE->MUL at edge N; busy=1 for cycles N+1..N+WIDTH.
  - MUL->DONE after WIDTH iterations; done=1 and busy=0 at cycle N+WIDTH+1; then back to IDLE.
- DIV (restoring, one quotient bit per cycle): same timing as MUL, WIDTH iterations.
- Divide-by-zero (b==0 at capture): no iteration. r = all ones, overflow=1, carry=0, done at N+1.
- Back-to-back: a start in a done cycle is accepted because busy=0 then. Throughput is one single-cycle op per clock.
- zero is always computed from the registered r as it is written.
- r and the flags change only on a done cycle or on reset. Intermediate accumulators are internal.

Optional Feature:
- Macro ALU_SHIFT_EN.
- Defined: 1100 sll gives r=a<<shamt; 1101 srl gives r=a>>shamt (logical). Single-cycle, carry=0, overflow=0.
- Not defined: 1100 and 1101 decode as undefined opcodes (r=0, zero=1), and shamt is unused.

Test Plan:
- WIDTH=8. Reset, then add a=8'h7F, b=8'h01 -> at N+1: done=1, r=8'h80, overflow=1, carry=0, zero=0, busy never 1.
- sub a=8'h05, b=8'h05 -> r=0, zero=1, carry=0; then sub a=8'h03, b=8'h05 back-to-back -> next cycle r=8'hFE, carry=1.
- mul a=8'h10, b=8'h11 -> busy 1 for 8 cycles, done at N+9, r=8'h10, overflow=1; start pulsed mid-run is ignored.
- div a=8'd200, b=8'd7 -> done at N+9, r=8'd28; div a=8'h55, b=0 -> done at N+1, r=8'hFF, overflow=1.
- Assert rst_n low during cycle N+4 of a mul -> all outputs return to reset values immediately; no done pulse follows.
- With ALU_SHIFT_EN: op 1100, a=8'h81, shamt=1 -> r=8'h02. Without the macro: same stimulus -> r=0, zero=1.
